// File: rtl/fp_pkg.sv
// Shared definitions for the FP writeback arbiter: formats, error codes
// and the arbiter priority state.
package fp_pkg;

    localparam logic [4:0] FMT_S = 5'h10;
    localparam logic [4:0] FMT_D = 5'h11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_FMT  = 2'b01;
    localparam logic [1:0] ERR_ODD  = 2'b10;
    localparam logic [1:0] ERR_R31  = 2'b11;

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fp_wb_check.sv
// Format/destination validation of the winning writeback transfer.
// drop = discard with error; suppress = silently skip (reg 0 is read-only).
module fp_wb_check
    import fp_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [4:0]        i_fmt,
    input  logic [REG_AW-1:0] i_reg,
    output logic              o_drop,
    output logic              o_suppress,
    output logic [1:0]        o_err_code
);

    always_comb begin
        o_drop     = 1'b0;
        o_suppress = 1'b0;
        o_err_code = ERR_NONE;
        if (i_fmt != FMT_S && i_fmt != FMT_D) begin
            o_drop     = 1'b1;
            o_err_code = ERR_FMT;
        end else if (i_fmt == FMT_D && i_reg == '1) begin
            // last register cannot hold a pair; reported ahead of odd-dest
            o_drop     = 1'b1;
            o_err_code = ERR_R31;
        end else if (i_fmt == FMT_D && i_reg[0]) begin
            o_drop     = 1'b1;
            o_err_code = ERR_ODD;
        end else if (i_reg == '0) begin
            o_suppress = 1'b1;
        end
    end

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP regfile write-port arbiter: A-priority with a starvation guard for B.
// Optional same-cycle forwarding port enabled by FP_WB_FWD_EN.
module fp_wb_arbiter
    import fp_pkg::*;
#(
    parameter int STARVE_LIMIT = 3,
    parameter int DATA_W       = 64,
    parameter int REG_AW       = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_reg,
    input  logic [4:0]        a_fmt,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_reg,
    input  logic [4:0]        b_fmt,
    input  logic [DATA_W-1:0] b_data,
    output logic              wr_en,
    output logic [REG_AW-1:0] wr_reg,
    output logic [4:0]        wr_fmt,
    output logic [DATA_W-1:0] wr_data,
    output logic              err_pulse,
    output logic [1:0]        err_code
`ifdef FP_WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_reg,
    output logic              fwd_dbl,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_nxt;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_xfer;
    logic [REG_AW-1:0] w_reg;
    logic [4:0]        w_fmt;
    logic [DATA_W-1:0] w_raw;
    logic [DATA_W-1:0] w_data;
    logic              w_drop;
    logic              w_suppress;
    logic [1:0]        w_err;
    logic              w_we;

    logic              r_wr_en;
    logic [REG_AW-1:0] r_wr_reg;
    logic [4:0]        r_wr_fmt;
    logic [DATA_W-1:0] r_wr_data;
    logic              r_err_pulse;
    logic [1:0]        r_err_code;

    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_b = 1'b0;
        if (r_state == PRI_B) begin
            w_gnt_b = b_valid;
            w_gnt_a = a_valid & ~b_valid;
        end else begin
            w_gnt_a = a_valid;
            w_gnt_b = b_valid & ~a_valid;
        end
    end

    assign a_ready = w_gnt_a;
    assign b_ready = w_gnt_b;
    assign w_xfer  = w_gnt_a | w_gnt_b;
    assign w_reg   = w_gnt_b ? b_reg  : a_reg;
    assign w_fmt   = w_gnt_b ? b_fmt  : a_fmt;
    assign w_raw   = w_gnt_b ? b_data : a_data;
    assign w_data  = (w_fmt == FMT_S) ?
                     {{(DATA_W-32){1'b0}}, w_raw[31:0]} : w_raw;

    fp_wb_check #(.REG_AW(REG_AW)) u_check (
        .i_fmt      (w_fmt),
        .i_reg      (w_reg),
        .o_drop     (w_drop),
        .o_suppress (w_suppress),
        .o_err_code (w_err)
    );

    assign w_we = w_xfer & ~w_drop & ~w_suppress;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        unique case (r_state)
            PRI_A: begin
                if (b_valid && w_gnt_a)
                    w_cnt_nxt = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
                if (b_valid && w_cnt_nxt == CNT_MAX)
                    w_state_nxt = PRI_B;
            end
            PRI_B: begin
                // B is either granted now or has withdrawn: both end PRI_B
                w_state_nxt = PRI_A;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PRI_A;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_wr_reg    <= '0;
            r_wr_fmt    <= '0;
            r_wr_data   <= '0;
            r_err_pulse <= 1'b0;
            r_err_code  <= ERR_NONE;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_wr_en     <= w_we;
            r_err_pulse <= w_xfer & w_drop;
            if (w_we) begin
                r_wr_reg  <= w_reg;
                r_wr_fmt  <= w_fmt;
                r_wr_data <= w_data;
            end
            if (w_xfer && w_drop)
                r_err_code <= w_err;
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_reg    = r_wr_reg;
    assign wr_fmt    = r_wr_fmt;
    assign wr_data   = r_wr_data;
    assign err_pulse = r_err_pulse;
    assign err_code  = r_err_code;

`ifdef FP_WB_FWD_EN
    assign fwd_valid = w_we;
    assign fwd_reg   = w_reg;
    assign fwd_dbl   = (w_fmt == FMT_D);
    assign fwd_data  = w_data;
`endif

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Randomized bench for fp_wb_arbiter against a rule-level reference model.
// Forwarding checks are active when FP_WB_FWD_EN is defined.
module tb_fp_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_valid, b_valid;
    logic        a_ready, b_ready;
    logic [4:0]  a_reg, b_reg, a_fmt, b_fmt;
    logic [63:0] a_data, b_data;
    logic        wr_en, err_pulse;
    logic [4:0]  wr_reg, wr_fmt;
    logic [63:0] wr_data;
    logic [1:0]  err_code;
`ifdef FP_WB_FWD_EN
    logic        fwd_valid, fwd_dbl;
    logic [4:0]  fwd_reg;
    logic [63:0] fwd_data;
`endif

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    bit          m_bprio;
    int          m_loss;
    logic [1:0]  m_code;
    logic        obs_b;

    always #5 clk = ~clk;

    fp_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .a_reg     (a_reg),
        .a_fmt     (a_fmt),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .b_reg     (b_reg),
        .b_fmt     (b_fmt),
        .b_data    (b_data),
        .wr_en     (wr_en),
        .wr_reg    (wr_reg),
        .wr_fmt    (wr_fmt),
        .wr_data   (wr_data),
        .err_pulse (err_pulse),
        .err_code  (err_code)
`ifdef FP_WB_FWD_EN
        ,
        .fwd_valid (fwd_valid),
        .fwd_reg   (fwd_reg),
        .fwd_dbl   (fwd_dbl),
        .fwd_data  (fwd_data)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_bprio = 0;
        m_loss  = 0;
        m_code  = 2'b00;
    endtask

    function automatic void judge(input logic [4:0] f, input logic [4:0] r,
                                  input logic [63:0] d, output logic en,
                                  output logic drop, output logic [1:0] code,
                                  output logic [63:0] dout);
        en   = 0;
        drop = 0;
        code = 2'b00;
        dout = (f == 5'h10) ? {32'h0, d[31:0]} : d;
        if (f != 5'h10 && f != 5'h11) begin
            drop = 1; code = 2'b01;
        end else if (f == 5'h11 && r == 5'd31) begin
            drop = 1; code = 2'b11;
        end else if (f == 5'h11 && r % 2 == 1) begin
            drop = 1; code = 2'b10;
        end else if (r != 0) begin
            en = 1;
        end
    endfunction

    task automatic step(input logic av, input logic [4:0] ar,
                        input logic [4:0] af, input logic [63:0] ad,
                        input logic bv, input logic [4:0] br,
                        input logic [4:0] bf, input logic [63:0] bd);
        logic ga, gb, en, drop;
        logic [1:0] code;
        logic [63:0] dd, sd;
        logic [4:0] sr, sf;
        @(negedge clk);
        a_valid = av; a_reg = ar; a_fmt = af; a_data = ad;
        b_valid = bv; b_reg = br; b_fmt = bf; b_data = bd;
        #1;
        if (m_bprio) begin
            gb = bv; ga = av & !bv;
        end else begin
            ga = av; gb = bv & !av;
        end
        chk("a_ready", a_ready, ga);
        chk("b_ready", b_ready, gb);
        obs_b = b_ready;
        sr = gb ? br : ar;
        sf = gb ? bf : af;
        sd = gb ? bd : ad;
        judge(sf, sr, sd, en, drop, code, dd);
        if (!(ga | gb)) begin
            en = 0; drop = 0;
        end
`ifdef FP_WB_FWD_EN
        chk("fwd_valid", fwd_valid, en);
        if (en) begin
            chk("fwd_reg", fwd_reg, sr);
            chk("fwd_dbl", fwd_dbl, sf == 5'h11);
            chk("fwd_data", fwd_data, dd);
        end
`endif
        @(posedge clk);
        #1;
        if (m_bprio) begin
            m_bprio = 0; m_loss = 0;
        end else if (bv && ga) begin
            m_loss = (m_loss < 3) ? m_loss + 1 : 3;
            if (m_loss == 3) m_bprio = 1;
        end else begin
            m_loss = 0;
        end
        if (drop) m_code = code;
        chk("wr_en", wr_en, en);
        chk("err_pulse", err_pulse, drop);
        chk("err_code", err_code, m_code);
        if (en) begin
            chk("wr_reg", wr_reg, sr);
            chk("wr_fmt", wr_fmt, sf);
            chk("wr_data", wr_data, dd);
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic logic [4:0] rnd_fmt();
        int k;
        k = $urandom_range(0, 7);
        if (k < 3) return 5'h10;
        if (k < 6) return 5'h11;
        if (k == 6) return 5'h14;
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        rst_n = 0;
        a_valid = 0; a_reg = 0; a_fmt = 0; a_data = 0;
        b_valid = 0; b_reg = 0; b_fmt = 0; b_data = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_reg", wr_reg, 0);
        chk("rst_wr_fmt", wr_fmt, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        @(negedge clk);
        rst_n = 1;

        // single write from A: upper half cleared
        step(1, 5'd4, 5'h10, 64'hAAAA_BBBB_1234_5678, 0, 0, 0, 0);
        chk("t1_data", wr_data, 64'h0000_0000_1234_5678);
        idle();
        chk("t1_hold_reg", wr_reg, 5'd4);
        chk("t1_hold_data", wr_data, 64'h0000_0000_1234_5678);

        // both valid: B wins every fourth cycle
        for (int i = 0; i < 8; i++) begin
            step(1, 5'd2, 5'h10, 64'h1, 1, 5'd8, 5'h11, 64'h2);
            chk("t2_b_gnt", obs_b, (i % 4) == 3);
        end
        idle();

        step(0, 0, 0, 0, 1, 5'd6, 5'h11, 64'h1111_2222_3333_4444);
        chk("t3_data", wr_data, 64'h1111_2222_3333_4444);

        step(0, 0, 0, 0, 1, 5'd7, 5'h11, 64'h5);
        chk("t4_odd", err_code, 2'b10);
        step(1, 5'd10, 5'h10, 64'h9, 0, 0, 0, 0);
        chk("t4_held", err_code, 2'b10);
        step(0, 0, 0, 0, 1, 5'd31, 5'h11, 64'h5);
        chk("t4_r31", err_code, 2'b11);
        step(0, 0, 0, 0, 1, 5'd12, 5'h14, 64'h5);
        chk("t4_fmt", err_code, 2'b01);

        step(1, 5'd0, 5'h10, 64'h77, 0, 0, 0, 0);
        step(1, 5'd0, 5'h11, 64'h77, 0, 0, 0, 0);

        // async reset right after a write, with B partially starved
        step(1, 5'd2, 5'h10, 64'h3, 1, 5'd8, 5'h11, 64'h4);
        step(1, 5'd8, 5'h10, 64'h3, 1, 5'd8, 5'h11, 64'h4);
        chk("t6_pre_en", wr_en, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_async_en", wr_en, 0);
        chk("t6_async_code", err_code, 0);
        model_reset();
        @(negedge clk);
        a_valid = 0; b_valid = 0;
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            step(1, 5'd2, 5'h10, 64'h1, 1, 5'd8, 5'h11, 64'h2);
            chk("t6_b_gnt", obs_b, i == 3);
        end

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
                 rnd_fmt(), {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, 5'($urandom_range(0, 31)),
                 rnd_fmt(), {$urandom, $urandom});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
